instr_fetch: RTL
================

# instr_fetch

Instruction sequencer directly upstream of `simple_cpu`. It stores a small program in an internal writable array and drives `simple_cpu.instruction`. Each instruction is held stable for exactly the number of cycles the CPU control unit FSM needs to retire it. After reset the output is a NOP (type 00), which keeps the CPU parked in its RESET state until a run is started.

## Interface
- `INSTR_WIDTH`, 20, instruction word width; field layout is [19:18] type, [17:16] X1/z, [15:14] X2, [13:12] X3, [11:4] offset, [3:0] opcode.
- `PC_BITS`, 4, program address width; the array depth is 2**PC_BITS.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- `prog_we`  in  1  program write enable; ignored unless the state is IDLE.
- `prog_addr`  in  PC_BITS  program write address.
- `prog_data`  in  INSTR_WIDTH  program write data.
- `instruction`  out  INSTR_WIDTH  registered instruction to the CPU.
- `pc`  out  PC_BITS  address of the word currently on `instruction`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE; sticky until `rst`.
- `instr_count`  out  PC_BITS+1  number of instructions issued in this run.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Retire length L(type):
  - 01 (std_op): L = 3.
  - 10 (loadR): L = 4.
  - 11 (storeR): L = 3.
  - 00: halt marker; never issued.
- IDLE:
  - `instruction` = 0.
  - `prog_we` writes `mem[prog_addr] <= prog_data`.
  - On `start`, read `mem[0]`:
    - If its type is 00: go to DONE and issue nothing.
    - Otherwise: load it into `instruction`, set `pc` = 0, `hold` = L+1 (one lead-in cycle for the CPU's RESET→DECODE transition), set `instr_count` = 1, go to RUN.
- RUN:
  - `hold` decrements every cycle.
  - On the cycle where `hold` == 1, the next word `mem[pc+1]` is examined at that edge:
    - If `pc` is the last address (2**PC_BITS−1) or the next word's type is 00: `instruction` <= 0, go to DONE.
    - Otherwise: `instruction` <= next word, `pc` <= pc+1, `hold` <= L(next), `instr_count` += 1.
- DONE:
  - `instruction` = 0 and `pc` holds its last value.
  - `start` and `prog_we` are ignored.
  - Only `rst` exits DONE. The CPU must be reset alongside this block before a new run, because the lead-in assumes the CPU is in RESET.
- The program array is not cleared by `rst`; its contents persist across resets.

## Timing
- Reset values: `instruction` = 0, `pc` = 0, `busy` = 0, `done` = 0, `instr_count` = 0, `hold` = 0.
- `start` is sampled at edge E0. `instruction` = `mem[0]` is visible after E0 and stays stable for L+1 edges.
- Every later word is stable for exactly L edges, changing right after its last retire edge.
- Total run length for N issued words = 1 + ΣL cycles of `busy`. `done` rises in the cycle after the final hold cycle.
- `start` asserted together with `prog_we` in IDLE: the write completes at that edge, and the `mem[0]` read uses the pre-write value.
- `start` outside IDLE: ignored.
- `rst` asserted mid-RUN: immediate return to IDLE with all outputs at their reset values; a partially held instruction is dropped.
- `pc` never wraps. Reaching the last address always ends the run.

## Configuration
- `IFETCH_CYCLE_CNT_EN` defined:
  - Adds output `cycle_count` (16 bits).
  - Cleared by `rst`, increments every cycle `busy` = 1, saturates at 0xFFFF, and is frozen in DONE.
- `IFETCH_CYCLE_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with no start → `instruction` = 0, `busy` = 0, `done` = 0 for 20 cycles.
- `mem[0]` = 0x76000 (std R3 = R1 + R2), `mem[1]` = 0, start → 0x76000 held 4 cycles, then `instruction` = 0, `done` = 1, `instr_count` = 1. The CPU's R3 reads 3.
- Program {0x84040 (loadR), 0xE0050 (storeR), 0x76000} terminated by 0 → hold lengths 5, 3, 3; `pc` sequence 0, 1, 2; `instr_count` = 3; `busy` high 11 cycles (`cycle_count` = 11 when the macro is enabled).
- `mem[0]` = 0, start → DONE on the next edge; `instr_count` = 0; `instruction` is never nonzero.
- `rst` pulsed in the 2nd hold cycle of a loadR → outputs return to reset values asynchronously. A new start replays from `mem[0]`, proving the program persisted.
- All 16 words std_op → the run ends after `pc` = 15 with `instr_count` = 16 and no wrap. `prog_we` and `start` during RUN and DONE leave the array and state unchanged.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction sequencer feeding simple_cpu: plays a stored program, one word per CPU retire window.
// Latency: mem[0] appears one edge after start; each later word changes right after the last retire edge of its predecessor.
// Backpressure: none; the hold counter replaces a handshake, so each word is held for the CPU's fixed retire length.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset (program array is not cleared)
//   start             one-cycle run request, honoured in IDLE only
//   prog_we/addr/data program array write port, honoured in IDLE only
//   instruction       registered instruction word to the CPU (0 when not running)
//   pc                address of the word currently on instruction
//   busy / done       RUN / DONE state flags; done is sticky until rst
//   instr_count       number of words issued in the current run
//   cycle_count       (only with IFETCH_CYCLE_CNT_EN defined) saturating count of busy cycles
//
// Optional feature macro: IFETCH_CYCLE_CNT_EN

module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic [PC_BITS:0]       instr_count
`ifdef IFETCH_CYCLE_CNT_EN
  ,
  output logic [15:0]            cycle_count
`endif
);

  localparam int DEPTH = 1 << PC_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Retire length per instruction type; type 00 is a halt marker and never issued.
  function automatic logic [2:0] retire_len(input logic [1:0] itype);
    return (itype == 2'b10) ? 3'd4 : 3'd3;
  endfunction

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [2:0]             hold_q, hold_d;
  logic [PC_BITS:0]       cnt_q, cnt_d;

  logic [INSTR_WIDTH-1:0] first_word;
  logic [INSTR_WIDTH-1:0] next_word;
  logic [PC_BITS-1:0]     next_addr;
  logic [1:0]             first_type;
  logic [1:0]             next_type;
  logic                   pc_last;

  // Program storage has no reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Reads are combinational, so a start coincident with a write to mem[0]
  // sees the pre-write word.
  assign first_word = mem[0];
  assign first_type = first_word[INSTR_WIDTH-1 -: 2];
  assign next_addr  = pc_q + 1'b1;
  assign next_word  = mem[next_addr];
  assign next_type  = next_word[INSTR_WIDTH-1 -: 2];
  assign pc_last    = (pc_q == {PC_BITS{1'b1}});

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (first_type == 2'b00) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            instr_d = first_word;
            pc_d    = '0;
            // Extra lead-in cycle covers the CPU's RESET->DECODE step.
            hold_d  = retire_len(first_type) + 3'd1;
            cnt_d   = {{PC_BITS{1'b0}}, 1'b1};
          end
        end
      end
      S_RUN: begin
        if (hold_q == 3'd1) begin
          // pc never wraps: the last address always ends the run.
          if (pc_last || (next_type == 2'b00)) begin
            state_d = S_DONE;
            instr_d = '0;
            hold_d  = '0;
          end else begin
            instr_d = next_word;
            pc_d    = next_addr;
            hold_d  = retire_len(next_type);
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          hold_d = hold_q - 3'd1;
        end
      end
      default: begin
        // DONE is sticky; only rst leaves it.
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign instr_count = cnt_q;

`ifdef IFETCH_CYCLE_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == S_RUN) && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_count = cyc_q;
`endif

endmodule
